// File: rtl/router_ctrl.sv
// Packet controller for the 1x3 router: header decode, FIFO steering, parity check and
// optional stale-output soft reset (enabled by defining SOFT_RESET_TIMEOUT_EN).
module router_ctrl #(
    parameter int         TIMEOUT     = 30,
    parameter logic [7:0] PARITY_INIT = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    output logic [7:0] fifo_data,
    output logic [2:0] write_enb,
    output logic       lfd_state,
    output logic       busy,
    output logic [2:0] vld_out,
    output logic [2:0] soft_reset,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_EMPTY,
        LOAD_FIRST,
        LOAD_DATA,
        FIFO_FULL,
        LOAD_PARITY,
        CHECK_PARITY,
        DROP
    } state_t;

    state_t     state_reg;
    logic [7:0] hdr_reg;
    logic [1:0] addr_reg;
    logic [5:0] cnt_reg;
    logic [7:0] parity_reg;
    logic [7:0] rx_par_reg;
    logic       err_reg;

    logic [5:0] len;
    logic [3:0] full_x;
    logic [3:0] empty_x;
    logic       sel_full;
    logic       sel_empty;
    logic [2:0] sel_onehot;
    logic       wr_ok;
    logic       abort;

    assign len       = hdr_reg[7:2];
    // Address 3 has no FIFO; padding the flag vectors keeps the lookup in range.
    assign full_x    = {1'b0, fifo_full};
    assign empty_x   = {1'b0, fifo_empty};
    assign sel_full  = full_x[addr_reg];
    assign sel_empty = empty_x[addr_reg];
    assign wr_ok     = pkt_valid && !sel_full;
    assign vld_out   = ~fifo_empty;
    assign err       = err_reg;

    always_comb begin
        sel_onehot = 3'b000;
        case (addr_reg)
            2'd0:    sel_onehot = 3'b001;
            2'd1:    sel_onehot = 3'b010;
            2'd2:    sel_onehot = 3'b100;
            default: sel_onehot = 3'b000;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        write_enb = 3'b000;
        lfd_state = 1'b0;
        fifo_data = data_in;
        case (state_reg)
            WAIT_EMPTY, FIFO_FULL, CHECK_PARITY: busy = 1'b1;
            LOAD_FIRST: begin
                busy      = 1'b1;
                lfd_state = 1'b1;
                write_enb = sel_onehot;
                fifo_data = hdr_reg;
            end
            LOAD_DATA, LOAD_PARITY: begin
                busy = sel_full;
                if (wr_ok)
                    write_enb = sel_onehot;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            hdr_reg    <= 8'h00;
            addr_reg   <= 2'd0;
            cnt_reg    <= 6'd0;
            parity_reg <= 8'h00;
            rx_par_reg <= 8'h00;
            err_reg    <= 1'b0;
        end else if (abort) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pkt_valid) begin
                        hdr_reg    <= data_in;
                        addr_reg   <= data_in[1:0];
                        cnt_reg    <= 6'd0;
                        parity_reg <= PARITY_INIT ^ data_in;
                        err_reg    <= 1'b0;
                        if (data_in[1:0] == 2'd3)
                            state_reg <= DROP;
                        else if (empty_x[data_in[1:0]])
                            state_reg <= LOAD_FIRST;
                        else
                            state_reg <= WAIT_EMPTY;
                    end
                end
                WAIT_EMPTY: begin
                    if (sel_empty)
                        state_reg <= LOAD_FIRST;
                end
                LOAD_FIRST: begin
                    state_reg <= (len == 6'd0) ? LOAD_PARITY : LOAD_DATA;
                end
                LOAD_DATA: begin
                    // A full FIFO parks the byte on data_in; it is re-offered once space frees up.
                    if (sel_full) begin
                        state_reg <= FIFO_FULL;
                    end else if (pkt_valid) begin
                        parity_reg <= parity_reg ^ data_in;
                        cnt_reg    <= cnt_reg + 6'd1;
                        if (cnt_reg == len - 6'd1)
                            state_reg <= LOAD_PARITY;
                    end
                end
                FIFO_FULL: begin
                    if (!sel_full)
                        state_reg <= LOAD_DATA;
                end
                LOAD_PARITY: begin
                    if (wr_ok) begin
                        rx_par_reg <= data_in;
                        state_reg  <= CHECK_PARITY;
                    end
                end
                CHECK_PARITY: begin
                    err_reg   <= (rx_par_reg != parity_reg);
                    state_reg <= IDLE;
                end
                DROP: begin
                    // Payload plus the trailing parity byte are swallowed: len+1 bytes in all.
                    if (pkt_valid) begin
                        if (cnt_reg == len)
                            state_reg <= IDLE;
                        else
                            cnt_reg <= cnt_reg + 6'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef SOFT_RESET_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [3:0] srst_x;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_timer
            logic [TW-1:0] timer_reg;
            logic          pulse_reg;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    timer_reg <= '0;
                    pulse_reg <= 1'b0;
                end else if (vld_out[gi] && !read_enb[gi]) begin
                    if (timer_reg == TW'(TIMEOUT - 1)) begin
                        timer_reg <= '0;
                        pulse_reg <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                        pulse_reg <= 1'b0;
                    end
                end else begin
                    timer_reg <= '0;
                    pulse_reg <= 1'b0;
                end
            end

            assign soft_reset[gi] = pulse_reg;
        end
    endgenerate

    // A flushed destination FIFO invalidates the packet in flight, so return to IDLE.
    assign srst_x = {1'b0, soft_reset};
    assign abort  = srst_x[addr_reg] &&
                    (state_reg inside {WAIT_EMPTY, LOAD_FIRST, LOAD_DATA, FIFO_FULL, LOAD_PARITY});
`else
    logic unused_timeout_inputs;

    assign soft_reset            = 3'b000;
    assign abort                 = 1'b0;
    assign unused_timeout_inputs = ^{read_enb, 32'(TIMEOUT)};
`endif

endmodule
